// File: rtl/shoot_pulse_gen_pkg.sv
// ---------------------------------------------------------------------------
// shoot_pkg
//
// Purpose:
//   Shared types and constants for the shoot pulse generator: the FSM state
//   enum, the Avalon-MM register addresses, the CTRL/STATUS bit positions
//   and the PULSE_US clamp helper.
//
// Ports:
//   None. This is a package and holds no logic.
//
// Configuration macro used by the users of this package: SHOOT_IRQ_EN.
// ---------------------------------------------------------------------------
package shoot_pkg;

  // FSM states of the shot sequencer.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FIRE = 2'd1,
    S_COOL = 2'd2
  } state_t;

  // Register map addresses.
  localparam logic [1:0] ADDR_CTRL   = 2'd0;
  localparam logic [1:0] ADDR_PULSE  = 2'd1;
  localparam logic [1:0] ADDR_COOL   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  // CTRL register bit positions.
  localparam int CTRL_ARM    = 0;
  localparam int CTRL_MODE   = 1;
  localparam int CTRL_IRQ_EN = 2;

  // STATUS register bit positions.
  localparam int STAT_BUSY = 0;
  localparam int STAT_CAP  = 1;
  localparam int STAT_DONE = 2;

  // Limit a requested pulse width to the largest value the hardware allows.
  function automatic logic [15:0] clamp_pulse(input logic [15:0] value,
                                              input logic [15:0] max_value);
    logic [15:0] result;
    result = (value > max_value) ? max_value : value;
    return result;
  endfunction

endpackage

// File: rtl/shoot_tick_gen.sv
// ---------------------------------------------------------------------------
// shoot_tick_gen
//
// Purpose:
//   Microsecond timebase prescaler. Counts clk cycles and raises o_tick for
//   one cycle out of every TICK_DIV. A synchronous clear restarts the count
//   so that a freshly started interval always lasts a whole number of ticks.
//
// Ports:
//   clk      in   system clock
//   reset_n  in   synchronous active-low reset
//   i_clear  in   synchronous clear of the prescaler count
//   o_tick   out  one-cycle pulse every TICK_DIV cycles
//
// Parameters:
//   TICK_DIV  clk cycles per tick
// ---------------------------------------------------------------------------
module shoot_tick_gen #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_clear,
  output logic o_tick
);

  // A divider of 1 still needs a one-bit counter to stay legal.
  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;

  // Wrap at LAST; the clear takes effect on the edge where it is asserted,
  // so the first tick after a clear arrives exactly TICK_DIV cycles later.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clear || (r_cnt == LAST)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/shoot_pulse_gen.sv
// ---------------------------------------------------------------------------
// shoot_pulse_gen
//
// Purpose:
//   Turns the software shoot request (shoot PIO out_port) into a single,
//   timed solenoid gate pulse on either the flat-kick or the chip-kick
//   driver, then holds off further shots for a programmable cooldown.
//   Pulse width, cooldown and mode are set over a small Avalon-MM slave.
//
// Ports:
//   clk         in   system clock
//   reset_n     in   synchronous active-low reset
//   address     in   register select (CTRL, PULSE_US, COOLDOWN_US, STATUS)
//   chipselect  in   slave select
//   write_n     in   active-low write strobe
//   writedata   in   write data
//   readdata    out  combinational read mux, undefined bits read 0
//   shoot_trig  in   shoot request, rising edge fires
//   cap_ready   in   capacitor-charged flag, asynchronous
//   kick_out    out  flat-kick solenoid gate, registered
//   chip_out    out  chip-kick solenoid gate, registered
//   busy        out  high while firing or cooling down
//   irq         out  DONE interrupt, registered (only with SHOOT_IRQ_EN)
//
// Parameters:
//   TICK_DIV      clk cycles per 1 us tick
//   MAX_PULSE_US  upper clamp for PULSE_US writes
//   COOL_RST_US   reset value of COOLDOWN_US
//
// Configuration macro:
//   SHOOT_IRQ_EN  adds the irq output and the CTRL IRQ_EN bit. Without it
//                 CTRL bit2 reads 0 and ignores writes.
// ---------------------------------------------------------------------------
module shoot_pulse_gen
  import shoot_pkg::*;
#(
  parameter int TICK_DIV     = 50,
  parameter int MAX_PULSE_US = 8000,
  parameter int COOL_RST_US  = 20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  output logic [15:0] readdata,
  input  logic        shoot_trig,
  input  logic        cap_ready,
  output logic        kick_out,
  output logic        chip_out,
  output logic        busy
`ifdef SHOOT_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam logic [15:0] MAX_PULSE = 16'(MAX_PULSE_US);
  localparam logic [15:0] COOL_RST  = 16'(COOL_RST_US);

  // Software-visible registers.
  logic        r_arm;
  logic        r_mode;
  logic [15:0] r_pulse;
  logic [15:0] r_cool;
  logic        r_done;

  // Input conditioning.
  logic r_cap_meta;
  logic r_cap_s;
  logic r_trig_q;

  // Shot sequencer state and per-shot latched values.
  state_t      r_state;
  logic [15:0] r_pulse_lat;
  logic [15:0] r_cool_lat;
  logic [15:0] r_tick_cnt;
  logic        r_kick;
  logic        r_chip;

  logic w_wr;
  logic w_status_wr;
  logic w_edge;
  logic w_tick;
  logic w_fire_start;
  logic w_fire_end;
  logic w_cool_end;
  logic w_clear;
  logic w_done_next;

  assign w_wr        = chipselect && !write_n;
  assign w_status_wr = w_wr && (address == ADDR_STATUS);

  // cap_ready comes from the charger board with no relation to clk, so it
  // is brought in through two flops before the sequencer looks at it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_cap_meta <= 1'b0;
      r_cap_s    <= 1'b0;
      r_trig_q   <= 1'b0;
    end else begin
      r_cap_meta <= cap_ready;
      r_cap_s    <= r_cap_meta;
      r_trig_q   <= shoot_trig;
    end
  end

  // Only a fresh 0 -> 1 transition is a shot request; a held-high
  // trigger never re-fires.
  assign w_edge = shoot_trig && !r_trig_q;

  // Sequencer decisions. A shot starts only from IDLE; FIRE ends either
  // when the latched width has elapsed or when ARM is withdrawn; COOL ends
  // after the latched cooldown, or straight away when it is zero.
  assign w_fire_start = (r_state == S_IDLE) && w_edge && r_arm && r_cap_s &&
                        (r_pulse != 16'd0);
  assign w_fire_end   = (r_state == S_FIRE) &&
                        (!r_arm ||
                         (w_tick && (r_tick_cnt == (r_pulse_lat - 16'd1))));
  assign w_cool_end   = (r_state == S_COOL) &&
                        ((r_cool_lat == 16'd0) ||
                         (w_tick && (r_tick_cnt == (r_cool_lat - 16'd1))));

  // Restart the prescaler on entry to FIRE and to COOL so both intervals
  // are exact multiples of TICK_DIV cycles.
  assign w_clear = w_fire_start || w_fire_end;

  shoot_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clear (w_clear),
    .o_tick  (w_tick)
  );

  // DONE is sticky: set as the shot returns to IDLE, cleared by any write to
  // STATUS. A completion on the same edge as the clear is kept.
  assign w_done_next = w_cool_end || (r_done && !w_status_wr);

  // Register file writes. Writes land at any time; the current shot keeps
  // its own latched copies, so mid-shot writes only affect the next shot.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_arm   <= 1'b0;
      r_mode  <= 1'b0;
      r_pulse <= 16'd0;
      r_cool  <= COOL_RST;
    end else if (w_wr) begin
      case (address)
        ADDR_CTRL: begin
          r_arm  <= writedata[CTRL_ARM];
          r_mode <= writedata[CTRL_MODE];
        end
        ADDR_PULSE: r_pulse <= clamp_pulse(writedata, MAX_PULSE);
        ADDR_COOL:  r_cool  <= writedata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_next;
    end
  end

`ifdef SHOOT_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  logic w_irq_en_next;

  assign w_irq_en_next = (w_wr && (address == ADDR_CTRL)) ?
                         writedata[CTRL_IRQ_EN] : r_irq_en;

  // irq is built from the next-state values so it rises on the same edge
  // as DONE and falls on the edge of the STATUS write that clears it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      r_irq_en <= w_irq_en_next;
      r_irq    <= w_done_next && w_irq_en_next;
    end
  end

  assign irq = r_irq;
`endif

  // Shot sequencer. The gate for the latched mode is raised on the same
  // edge that leaves IDLE and lowered on the edge that enters COOL, so the
  // two gates can never be high together. The tick counter restarts on
  // every state entry and compares against (length - 1) because the tick
  // that closes an interval is the length-th one.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_pulse_lat <= 16'd0;
      r_cool_lat  <= 16'd0;
      r_tick_cnt  <= 16'd0;
      r_kick      <= 1'b0;
      r_chip      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire_start) begin
            r_state     <= S_FIRE;
            r_pulse_lat <= r_pulse;
            r_tick_cnt  <= 16'd0;
            r_kick      <= !r_mode;
            r_chip      <= r_mode;
          end
        end
        S_FIRE: begin
          if (w_fire_end) begin
            r_state    <= S_COOL;
            r_cool_lat <= r_cool;
            r_tick_cnt <= 16'd0;
            r_kick     <= 1'b0;
            r_chip     <= 1'b0;
          end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
          end
        end
        S_COOL: begin
          if (w_cool_end) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= 16'd0;
          end else if (w_tick) begin
            r_tick_cnt <= r_tick_cnt + 16'd1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_kick  <= 1'b0;
          r_chip  <= 1'b0;
        end
      endcase
    end
  end

  assign kick_out = r_kick;
  assign chip_out = r_chip;
  assign busy     = (r_state != S_IDLE);

  // Register read mux.
  always_comb begin
    readdata = 16'd0;
    case (address)
      ADDR_CTRL: begin
        readdata[CTRL_ARM]  = r_arm;
        readdata[CTRL_MODE] = r_mode;
`ifdef SHOOT_IRQ_EN
        readdata[CTRL_IRQ_EN] = r_irq_en;
`endif
      end
      ADDR_PULSE:  readdata = r_pulse;
      ADDR_COOL:   readdata = r_cool;
      ADDR_STATUS: begin
        readdata[STAT_BUSY] = busy;
        readdata[STAT_CAP]  = r_cap_s;
        readdata[STAT_DONE] = r_done;
      end
      default: readdata = 16'd0;
    endcase
  end

endmodule

// File: tb/tb_shoot_pulse_gen.sv
// ---------------------------------------------------------------------------
// tb_shoot_pulse_gen
//
// Purpose:
//   Self-checking bench for shoot_pulse_gen. A reference model describes
//   each shot by the clock-edge numbers at which the gate rises, the gate
//   falls and the unit returns to idle, and every cycle the DUT outputs and
//   read mux are compared against what those edge numbers imply. Directed
//   shots cover the nominal flat/chip pulses, clamp, interlocks, abort and
//   reset; a randomized phase then mixes register writes, trigger toggles
//   and cap_ready changes.
//
// Ports: none (top-level bench).
//
// Configuration macro: SHOOT_IRQ_EN (connects and checks irq when defined).
// ---------------------------------------------------------------------------
module tb_shoot_pulse_gen;

  localparam int TICK_DIV     = 50;
  localparam int MAX_PULSE_US = 8000;
  localparam int COOL_RST_US  = 20000;
  localparam int NONE         = 32'h7fffffff;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;
  logic        shoot_trig;
  logic        cap_ready;
  logic        kick_out;
  logic        chip_out;
  logic        busy;
`ifdef SHOOT_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state: edge counter, shot edge numbers, registers.
  int          n;
  int          fEdge;
  int          gEdge;
  int          eEdge;
  logic        mArm;
  logic        mMode;
  logic        mIrqEn;
  logic [15:0] mPulse;
  logic [15:0] mCool;
  logic        mDone;
  logic        mGateChip;
  logic        capD1;
  logic        capD2;
  logic        trigPrev;

  // Measurement counters for the directed length checks.
  int kickCnt;
  int chipCnt;
  int busyCnt;

  shoot_pulse_gen #(
    .TICK_DIV     (TICK_DIV),
    .MAX_PULSE_US (MAX_PULSE_US),
    .COOL_RST_US  (COOL_RST_US)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .shoot_trig (shoot_trig),
    .cap_ready  (cap_ready),
    .kick_out   (kick_out),
    .chip_out   (chip_out),
    .busy       (busy)
`ifdef SHOOT_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  // 100 MHz-style free-running bench clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check, reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, n);
    end
  endtask

  // Advance the model by one clock edge using the inputs the DUT saw.
  task automatic modelEdge();
    logic        edgeDet;
    logic        idle;
    logic        fireAct;
    logic        capUsed;
    logic        doneSet;
    logic        armOld;
    logic        modeOld;
    logic [15:0] pulseOld;
    logic [15:0] coolOld;
    n++;
    if (!reset_n) begin
      mArm = 1'b0; mMode = 1'b0; mIrqEn = 1'b0; mDone = 1'b0;
      mPulse = 16'd0; mCool = 16'(COOL_RST_US);
      fEdge = NONE; gEdge = NONE; eEdge = NONE;
      capD1 = 1'b0; capD2 = 1'b0; trigPrev = 1'b0;
      return;
    end
    capUsed  = capD2;
    armOld   = mArm;
    modeOld  = mMode;
    pulseOld = mPulse;
    coolOld  = mCool;
    edgeDet  = shoot_trig && !trigPrev;
    idle     = !((fEdge != NONE) && (fEdge <= n - 1) && (n - 1 < eEdge));
    fireAct  = (fEdge != NONE) && (fEdge <= n - 1) && (n - 1 < gEdge);
    doneSet  = 1'b0;
    if (idle) begin
      if (edgeDet && armOld && capUsed && (pulseOld != 16'd0)) begin
        fEdge = n;
        gEdge = n + int'(pulseOld) * TICK_DIV;
        eEdge = NONE;
        mGateChip = modeOld;
      end
    end else if (fireAct) begin
      if (!armOld) gEdge = n;
      if (n == gEdge)
        eEdge = n + ((coolOld == 16'd0) ? 1 : int'(coolOld) * TICK_DIV);
    end else if (n == eEdge) begin
      doneSet = 1'b1;
    end
    if (chipselect && !write_n) begin
      case (address)
        2'd0: begin
          mArm  = writedata[0];
          mMode = writedata[1];
`ifdef SHOOT_IRQ_EN
          mIrqEn = writedata[2];
`endif
        end
        2'd1: mPulse = (writedata > 16'(MAX_PULSE_US)) ? 16'(MAX_PULSE_US) : writedata;
        2'd2: mCool = writedata;
        default: mDone = 1'b0;
      endcase
    end
    if (doneSet) mDone = 1'b1;
    capD2    = capD1;
    capD1    = cap_ready;
    trigPrev = shoot_trig;
  endtask

  function automatic logic expBusy();
    return (fEdge != NONE) && (fEdge <= n) && (n < eEdge);
  endfunction

  function automatic logic expGate();
    return (fEdge != NONE) && (fEdge <= n) && (n < gEdge);
  endfunction

  function automatic logic [15:0] expRead(input logic [1:0] a);
    logic [15:0] v;
    v = 16'd0;
    case (a)
      2'd0: begin
        v[0] = mArm;
        v[1] = mMode;
`ifdef SHOOT_IRQ_EN
        v[2] = mIrqEn;
`endif
      end
      2'd1: v = mPulse;
      2'd2: v = mCool;
      default: begin
        v[0] = expBusy();
        v[1] = capD2;
        v[2] = mDone;
      end
    endcase
    return v;
  endfunction

  // Run the given number of clock cycles, updating the model at each edge
  // and comparing every output shortly after the edge.
  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      modelEdge();
      #2;
      checkOutput("kick_out", kick_out, expGate() && !mGateChip);
      checkOutput("chip_out", chip_out, expGate() && mGateChip);
      checkOutput("busy", busy, expBusy());
      checkOutput("readdata", readdata, expRead(address));
`ifdef SHOOT_IRQ_EN
      checkOutput("irq", irq, mDone && mIrqEn);
`endif
      if (kick_out === 1'b1) kickCnt++;
      if (chip_out === 1'b1) chipCnt++;
      if (busy === 1'b1) busyCnt++;
    end
  endtask

  task automatic writeReg(input logic [1:0] a, input logic [15:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    applyStimulus(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic clearCounts();
    kickCnt = 0;
    chipCnt = 0;
    busyCnt = 0;
  endtask

  logic [15:0] rstVals [4];

  initial begin
    n = 0; fEdge = NONE; gEdge = NONE; eEdge = NONE;
    mArm = 0; mMode = 0; mIrqEn = 0; mPulse = 0; mCool = 16'(COOL_RST_US);
    mDone = 0; mGateChip = 0; capD1 = 0; capD2 = 0; trigPrev = 0;
    clearCounts();
    rstVals[0] = 16'd0; rstVals[1] = 16'd0;
    rstVals[2] = 16'(COOL_RST_US); rstVals[3] = 16'd0;

    reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; write_n = 1'b1;
    writedata = 16'd0; shoot_trig = 1'b0; cap_ready = 1'b0;

    // Reset state and register reset values.
    applyStimulus(3);
    reset_n = 1'b1;
    applyStimulus(2);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      checkOutput("reset_reg", readdata, rstVals[a]);
    end

    // PULSE_US clamp.
    writeReg(2'd1, 16'd9000);
    address = 2'd1;
    #1;
    checkOutput("pulse_clamp", readdata, 16'd8000);

    // Nominal flat shot with a second edge during FIRE and a held trigger.
    writeReg(2'd2, 16'd10);
    writeReg(2'd1, 16'd100);
    writeReg(2'd0, 16'd1);
    cap_ready = 1'b1;
    address = 2'd3;
    applyStimulus(4);
    clearCounts();
    shoot_trig = 1'b1;
    applyStimulus(1000);
    shoot_trig = 1'b0;
    applyStimulus(1);
    shoot_trig = 1'b1;
    applyStimulus(5000);
    checkOutput("flat_kick_len", kickCnt, 5000);
    checkOutput("flat_chip_len", chipCnt, 0);
    checkOutput("flat_busy_len", busyCnt, 5500);
    checkOutput("flat_done", readdata[2], 1'b1);
    writeReg(2'd3, 16'd0);
    address = 2'd3;
    #1;
    checkOutput("done_clear", readdata[2], 1'b0);

    // Chip shot.
    writeReg(2'd0, 16'd3);
    address = 2'd3;
    shoot_trig = 1'b0;
    applyStimulus(1);
    clearCounts();
    shoot_trig = 1'b1;
    applyStimulus(5600);
    checkOutput("chip_chip_len", chipCnt, 5000);
    checkOutput("chip_kick_len", kickCnt, 0);
    checkOutput("chip_busy_len", busyCnt, 5500);

    // Interlocks: no cap_ready, then no ARM.
    cap_ready = 1'b0;
    shoot_trig = 1'b0;
    applyStimulus(4);
    clearCounts();
    shoot_trig = 1'b1;
    applyStimulus(50);
    checkOutput("nocap_busy", busyCnt, 0);
    writeReg(2'd0, 16'd0);
    cap_ready = 1'b1;
    shoot_trig = 1'b0;
    applyStimulus(4);
    clearCounts();
    shoot_trig = 1'b1;
    applyStimulus(50);
    checkOutput("noarm_busy", busyCnt, 0);

    // ARM withdrawn 2000 cycles into FIRE: gate drops one edge after the write.
    writeReg(2'd0, 16'd1);
    shoot_trig = 1'b0;
    applyStimulus(2);
    clearCounts();
    shoot_trig = 1'b1;
    applyStimulus(2000);
    writeReg(2'd0, 16'd0);
    applyStimulus(700);
    checkOutput("abort_kick_len", kickCnt, 2001);
    checkOutput("abort_busy_len", busyCnt, 2501);

    // Reset 300 cycles into FIRE.
    writeReg(2'd0, 16'd1);
    shoot_trig = 1'b0;
    applyStimulus(2);
    clearCounts();
    shoot_trig = 1'b1;
    applyStimulus(300);
    reset_n = 1'b0;
    applyStimulus(1);
    reset_n = 1'b1;
    applyStimulus(20);
    checkOutput("reset_kick_len", kickCnt, 300);

    // Randomized phase.
    writeReg(2'd1, 16'd10);
    writeReg(2'd2, 16'd2);
    writeReg(2'd0, 16'd1);
    cap_ready = 1'b1;
    for (int it = 0; it < 90; it++) begin
      case ($urandom_range(0, 9))
        0: writeReg(2'd1, 16'($urandom_range(0, 20)));
        1: writeReg(2'd2, 16'($urandom_range(0, 6)));
        2: writeReg(2'd0, 16'($urandom_range(0, 7)));
        3: writeReg(2'd0, 16'($urandom_range(0, 7) | 1));
        4: cap_ready = ($urandom_range(0, 3) != 0);
        8: writeReg(2'd3, 16'($urandom_range(0, 65535)));
        9: begin
          address    = 2'($urandom_range(0, 3));
          chipselect = 1'b0;
          write_n    = 1'b0;
          writedata  = 16'($urandom_range(0, 65535));
          applyStimulus(1);
          write_n    = 1'b1;
        end
        default: shoot_trig = ~shoot_trig;
      endcase
      address = 2'($urandom_range(0, 3));
      applyStimulus($urandom_range(1, 300));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
